// File: rtl/pc_trace_check.sv
// Program-counter trace checker: compares execute-stage PC events against a
// queue of expected PCs and reports match count, first failure and pass/fail.
module pc_trace_check #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [31:0]      ie_pc,
    input  logic             exp_valid,
    input  logic [31:0]      exp_pc,
    input  logic             exp_last,
    output logic             exp_ready,
    output logic [CNT_W-1:0] match_cnt,
    output logic             mismatch,
    output logic             underflow,
    output logic [31:0]      err_pc_act,
    output logic [31:0]      err_pc_exp,
    output logic             done,
    output logic             pass
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StFail} state_t;

    state_t        state;
    logic [31:0]   prev_pc;

    // Expected-PC FIFO, entries are {last, pc}
    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          evt;
    logic [31:0]   head_pc;
    logic          head_last;

    // FIFO status, event detection and head decode
    always_comb begin
        full      = (count == (AW+1)'(DEPTH));
        empty     = (count == '0);
        // exp_ready is based on the registered fill level only, so a pop
        // while full never frees a slot for a push in the same cycle
        exp_ready = ~full;
        push      = exp_valid & ~full;
        evt       = en & ((state == StIdle) | ((state == StRun) & (ie_pc != prev_pc)));
        pop       = evt & ~empty & ~clr;
        head_pc   = mem[rd_ptr][31:0];
        head_last = mem[rd_ptr][32];
    end

    // FIFO storage; contents are meaningless outside the valid window
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= {exp_last, exp_pc};
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Previous-cycle PC, used to detect a new execute-stage PC in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pc <= '0;
        end else if (clr) begin
            prev_pc <= '0;
        end else begin
            prev_pc <= ie_pc;
        end
    end

    // Check FSM with registered results and status decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            match_cnt  <= '0;
            mismatch   <= 1'b0;
            underflow  <= 1'b0;
            err_pc_act <= '0;
            err_pc_exp <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (clr) begin
            state      <= StIdle;
            match_cnt  <= '0;
            mismatch   <= 1'b0;
            underflow  <= 1'b0;
            err_pc_act <= '0;
            err_pc_exp <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (evt) begin
                if (empty) begin
                    // A word pushed this cycle is not yet visible
                    state      <= StFail;
                    underflow  <= 1'b1;
                    err_pc_act <= ie_pc;
                    err_pc_exp <= '0;
                    done       <= 1'b1;
                    pass       <= 1'b0;
                end else if (head_pc == ie_pc) begin
                    if (match_cnt != '1) begin
                        match_cnt <= match_cnt + CNT_W'(1);
                    end
                    if (head_last) begin
                        state <= StDone;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        state <= StRun;
                    end
                end else begin
                    state      <= StFail;
                    mismatch   <= 1'b1;
                    err_pc_act <= ie_pc;
                    err_pc_exp <= head_pc;
                    done       <= 1'b1;
                    pass       <= 1'b0;
                end
            end else if (state == StRun && !en) begin
                state <= StIdle;
            end
        end
    end

endmodule

// File: tb/tb_pc_trace_check.sv
// Directed self-checking bench for pc_trace_check.
module tb_pc_trace_check;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             en;
    logic [31:0]      ie_pc;
    logic             exp_valid;
    logic [31:0]      exp_pc;
    logic             exp_last;
    logic             exp_ready;
    logic [CNT_W-1:0] match_cnt;
    logic             mismatch;
    logic             underflow;
    logic [31:0]      err_pc_act;
    logic [31:0]      err_pc_exp;
    logic             done;
    logic             pass;

    int n_checks = 0;
    int n_fails  = 0;

    pc_trace_check #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (en),
        .ie_pc     (ie_pc),
        .exp_valid (exp_valid),
        .exp_pc    (exp_pc),
        .exp_last  (exp_last),
        .exp_ready (exp_ready),
        .match_cnt (match_cnt),
        .mismatch  (mismatch),
        .underflow (underflow),
        .err_pc_act(err_pc_act),
        .err_pc_exp(err_pc_exp),
        .done      (done),
        .pass      (pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] pc, input logic last);
        exp_valid = 1'b1;
        exp_pc    = pc;
        exp_last  = last;
        tick();
        exp_valid = 1'b0;
        exp_last  = 1'b0;
    endtask

    task automatic do_clr();
        en  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        en        = 1'b0;
        ie_pc     = '0;
        exp_valid = 1'b0;
        exp_pc    = '0;
        exp_last  = 1'b0;
        #12;
        check("rst_ready", 32'(exp_ready), 32'd1);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_uflow", 32'(underflow), 32'd0);
        check("rst_err_act", err_pc_act, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Clean three-entry trace
        push_word(32'h100, 1'b0);
        push_word(32'h104, 1'b0);
        push_word(32'h108, 1'b1);
        en    = 1'b1;
        ie_pc = 32'h100;
        tick();
        check("t1_cnt1", 32'(match_cnt), 32'd1);
        check("t1_mm1", 32'(mismatch), 32'd0);
        ie_pc = 32'h104;
        tick();
        check("t1_cnt2", 32'(match_cnt), 32'd2);
        check("t1_mm2", 32'(mismatch), 32'd0);
        ie_pc = 32'h108;
        tick();
        check("t1_cnt3", 32'(match_cnt), 32'd3);
        check("t1_mm3", 32'(mismatch), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_pass", 32'(pass), 32'd1);
        ie_pc = 32'h10c;
        tick();
        check("t1_hold_cnt", 32'(match_cnt), 32'd3);
        do_clr();
        check("clr_cnt", 32'(match_cnt), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_pass", 32'(pass), 32'd0);

        // Mismatch on second event
        push_word(32'h200, 1'b0);
        push_word(32'h204, 1'b0);
        en    = 1'b1;
        ie_pc = 32'h200;
        tick();
        check("t2_cnt1", 32'(match_cnt), 32'd1);
        check("t2_mm0", 32'(mismatch), 32'd0);
        ie_pc = 32'h208;
        tick();
        check("t2_mm1", 32'(mismatch), 32'd1);
        check("t2_act", err_pc_act, 32'h208);
        check("t2_exp", err_pc_exp, 32'h204);
        check("t2_cnt", 32'(match_cnt), 32'd1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_pass", 32'(pass), 32'd0);
        ie_pc = 32'h20c;
        tick();
        check("t2_mm_pulse", 32'(mismatch), 32'd0);
        check("t2_act_held", err_pc_act, 32'h208);
        do_clr();

        // Fill to full; extra word refused, including during the freeing pop
        for (int i = 0; i < DEPTH; i++) begin
            check("t3_ready_pre", 32'(exp_ready), 32'd1);
            push_word(32'h500 + 32'(4 * i), 1'b0);
        end
        check("t3_full", 32'(exp_ready), 32'd0);
        exp_valid = 1'b1;
        exp_pc    = 32'h600;
        tick();
        check("t3_full_hold", 32'(exp_ready), 32'd0);
        en    = 1'b1;
        ie_pc = 32'h500;
        tick();
        exp_valid = 1'b0;
        check("t3_ready_back", 32'(exp_ready), 32'd1);
        check("t3_cnt1", 32'(match_cnt), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            ie_pc = 32'h500 + 32'(4 * i);
            tick();
        end
        check("t3_cnt_all", 32'(match_cnt), 32'(DEPTH));
        check("t3_not_done", 32'(done), 32'd0);
        ie_pc = 32'h600;
        tick();
        check("t3_uflow", 32'(underflow), 32'd1);
        check("t3_act", err_pc_act, 32'h600);
        do_clr();
        check("clr_uflow", 32'(underflow), 32'd0);

        // Underflow on first event; same-cycle push not compared
        en        = 1'b1;
        ie_pc     = 32'h300;
        exp_valid = 1'b1;
        exp_pc    = 32'h300;
        exp_last  = 1'b1;
        tick();
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        check("t4_uflow", 32'(underflow), 32'd1);
        check("t4_act", err_pc_act, 32'h300);
        check("t4_exp", err_pc_exp, 32'd0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_pass", 32'(pass), 32'd0);
        check("t4_mm", 32'(mismatch), 32'd0);
        check("t4_cnt", 32'(match_cnt), 32'd0);
        do_clr();

        // Held PC yields one pop only
        push_word(32'h400, 1'b0);
        push_word(32'h404, 1'b1);
        en    = 1'b1;
        ie_pc = 32'h400;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check("t5_cnt", 32'(match_cnt), 32'd1);
        check("t5_done", 32'(done), 32'd0);
        ie_pc = 32'h404;
        tick();
        check("t5_cnt2", 32'(match_cnt), 32'd2);
        check("t5_pass", 32'(pass), 32'd1);
        do_clr();

        // Asynchronous reset mid-RUN
        push_word(32'h700, 1'b0);
        push_word(32'h704, 1'b0);
        push_word(32'h708, 1'b0);
        push_word(32'h70c, 1'b1);
        en    = 1'b1;
        ie_pc = 32'h700;
        tick();
        check("t6_cnt_pre", 32'(match_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_cnt", 32'(match_cnt), 32'd0);
        check("t6_rst_ready", 32'(exp_ready), 32'd1);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_act", err_pc_act, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ie_pc = 32'h704;
        tick();
        check("t6_uflow", 32'(underflow), 32'd1);
        check("t6_act", err_pc_act, 32'h704);
        check("t6_pass", 32'(pass), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
